// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one full round per clock through a single reused round unit,
// driven by an externally supplied flat round-key schedule, valid/ready on both sides.
module aes_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [0:128*(Nr+1)-1]    round_keys,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out_data
);

  // A core whose round count does not match its key length never accepts a block.
  localparam bit CFG_OK = (Nr == Nk + 6);
  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*x +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t       r_fsm;
  logic [3:0]   r_round;
  logic [0:127] r_state;
  logic [0:127] r_out_data;
  logic         r_out_valid;
  logic         r_in_ready;

  logic [7:0]   w_sb [16];
  logic [7:0]   w_sr [16];
  logic [7:0]   w_mc [16];
  logic [0:127] w_pre_key;
  logic [0:127] w_round_key;
  logic [0:127] w_next_state;
  logic         w_last;
  logic         w_accept;

  assign w_last      = (r_round == LAST_ROUND);
  assign w_round_key = round_keys[128*r_round +: 128];
  assign w_accept    = CFG_OK && in_valid && r_in_ready && (r_fsm == IDLE);

  genvar gi;
  // Byte k sits at column k/4, row k%4; row r is rotated left by r columns.
  for (gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign w_sb[gi] = sbox(r_state[8*gi +: 8]);
    assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[4*gi+0];
    assign w_a1 = w_sr[4*gi+1];
    assign w_a2 = w_sr[4*gi+2];
    assign w_a3 = w_sr[4*gi+3];
    assign w_mc[4*gi+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mc[4*gi+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mc[4*gi+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mc[4*gi+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  for (gi = 0; gi < 16; gi++) begin : g_pre_key
    assign w_pre_key[8*gi +: 8] = w_last ? w_sr[gi] : w_mc[gi];
  end

  assign w_next_state = w_pre_key ^ w_round_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_round     <= 4'd0;
      r_state     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= in_data ^ round_keys[0 +: 128];
            r_round    <= 4'd1;
            r_in_ready <= 1'b0;
            r_fsm      <= RUN;
          end
        end
        RUN: begin
          r_state <= w_next_state;
          if (w_last) begin
            r_out_data  <= w_next_state;
            r_out_valid <= 1'b1;
            r_fsm       <= HOLD;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= IDLE;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
